// File: rtl/rgb_matrix_scanner_pkg.sv
// Shared types and defaults for the RGB matrix scanner: matrix size, scan states, row decode.
package rgb_matrix_pkg;

  localparam int DEFAULT_ROWS = 4;
  localparam int DEFAULT_COLS = 10;

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_t;

  function automatic logic [31:0] onehot_row(input int unsigned row);
    return 32'd1 << row;
  endfunction

endpackage

// File: rtl/rgb_matrix_scanner_if.sv
// Row-write inputs from the JTAG side and LED matrix drive outputs of the scanner.
// brightness exists only when RGB_MATRIX_PWM_EN is defined.
interface rgb_matrix_scanner_if
  import rgb_matrix_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS
);

  logic                    wr_toggle;
  logic [$clog2(ROWS)-1:0] wr_row;
  logic [3*COLS-1:0]       wr_data;
  logic [COLS-1:0]         red;
  logic [COLS-1:0]         green;
  logic [COLS-1:0]         blue;
  logic [ROWS-1:0]         rgbRow;
`ifdef RGB_MATRIX_PWM_EN
  logic [3:0]              brightness;

  modport master (output wr_toggle, wr_row, wr_data, brightness,
                  input  red, green, blue, rgbRow);
  modport slave  (input  wr_toggle, wr_row, wr_data, brightness,
                  output red, green, blue, rgbRow);
`else
  modport master (output wr_toggle, wr_row, wr_data,
                  input  red, green, blue, rgbRow);
  modport slave  (input  wr_toggle, wr_row, wr_data,
                  output red, green, blue, rgbRow);
`endif

endinterface

// File: rtl/rgb_matrix_scanner_toggle_sync.sv
// Brings the JTCK-domain write toggle into the system clock domain and
// turns each level change into a single-cycle pulse.
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic toggle,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_ref_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= '0;
      edge_ref_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], toggle};
      edge_ref_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] ^ edge_ref_q;

endmodule

// File: rtl/rgb_matrix_scanner.sv
// Frame buffer plus row scanner for a ROWS x COLS RGB LED matrix, written one row per JTAG update.
// Optional feature macro: RGB_MATRIX_PWM_EN (adds brightness gating of the colour columns).
module rgb_matrix_scanner
  import rgb_matrix_pkg::*;
#(
  parameter int ROWS         = DEFAULT_ROWS,
  parameter int COLS         = DEFAULT_COLS,
  parameter int ROW_CYCLES   = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input logic                 clock,
  input logic                 reset,
  rgb_matrix_scanner_if.slave bus
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROW_CYCLES > BLANK_CYCLES ? ROW_CYCLES : BLANK_CYCLES);

  logic wr_pulse;

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_toggle_sync (
    .clock  (clock),
    .reset  (reset),
    .toggle (bus.wr_toggle),
    .pulse  (wr_pulse)
  );

  logic [3*COLS-1:0] frame_q [ROWS];

  // NOTE: the frame buffer is deliberately reset so a reset blanks the picture, not just the scan.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) frame_q[i] <= '0;
    end else if (wr_pulse && ({1'b0, bus.wr_row} < (RW+1)'(ROWS))) begin
      frame_q[bus.wr_row] <= bus.wr_data;
    end
  end

  scan_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    row_d   = row_q;
    case (state_q)
      BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == CW'(ROW_CYCLES - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
          row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        end
      end
    endcase
  end

  logic              gate;
  logic [3*COLS-1:0] row_data;

`ifdef RGB_MATRIX_PWM_EN
  assign gate = (cnt_q[3:0] < bus.brightness);
`else
  assign gate = 1'b1;
`endif

  assign row_data = frame_q[row_q];

  logic [COLS-1:0] red_q, green_q, blue_q;
  logic [ROWS-1:0] rgb_row_q;

  // Outputs lag the scan state by one clock; blanking happens on the same lag.
  always_ff @(posedge clock) begin
    if (reset || state_q != DRIVE) begin
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      rgb_row_q <= '0;
    end else begin
      red_q     <= row_data[COLS-1:0]        & {COLS{gate}};
      green_q   <= row_data[2*COLS-1:COLS]   & {COLS{gate}};
      blue_q    <= row_data[3*COLS-1:2*COLS] & {COLS{gate}};
      rgb_row_q <= ROWS'(onehot_row(32'(row_q)));
    end
  end

  assign bus.red    = red_q;
  assign bus.green  = green_q;
  assign bus.blue   = blue_q;
  assign bus.rgbRow = rgb_row_q;

endmodule
